// File: rtl/wave_mem_loader_pkg.sv
// rtl/wave_mem_loader_pkg.sv - shared types and constants for the waveform memory loader
package wave_mem_loader_pkg;

  localparam int WAVE_ADDR_W = 5;
  localparam int WAVE_DATA_W = 4;
  localparam logic [2:0] OPCODE_DEFAULT = 3'b101;

  typedef enum logic [2:0] {
    WAIT_IDLE,
    IDLE,
    CMD,
    DATA,
    WR_HI,
    WR_LO,
    DISCARD
  } state_e;

endpackage

// File: rtl/wave_mem_loader_sync_edge.sv
// rtl/wave_mem_loader_sync_edge.sv - multi-flop synchroniser with rise/fall detection
module sync_edge #(
  parameter int   SYNC_STAGES = 2,
  parameter logic RESET_VAL   = 1'b0
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o,
  output logic rise_o,
  output logic fall_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  // Shift the async input through the synchroniser chain and keep a delayed copy for edges
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= {SYNC_STAGES{RESET_VAL}};
      prev_q <= RESET_VAL;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign q_o    = sync_q[SYNC_STAGES-1];
  assign rise_o = q_o & ~prev_q;
  assign fall_o = ~q_o & prev_q;

endmodule

// File: rtl/wave_mem_loader.sv
// rtl/wave_mem_loader.sv - SPI byte stream to nibble writes into the user waveform memory
module wave_mem_loader
  import wave_mem_loader_pkg::*;
#(
  parameter logic [2:0] OPCODE      = OPCODE_DEFAULT,
  parameter int         SYNC_STAGES = 2
) (
  input  logic                   clk_in,
  input  logic                   reset_n_in,
  input  logic                   spi_cs_n_in,
  input  logic                   spi_sclk_in,
  input  logic                   spi_mosi_in,
  output logic [WAVE_ADDR_W-1:0] mem_write_addr_out,
  output logic [WAVE_DATA_W-1:0] mem_write_data_out,
  output logic                   mem_write_en_out,
  output logic                   busy_out,
  output logic                   frame_done_out,
  output logic                   cmd_err_out
);

  // Cycles after reset release before the cs_n synchroniser shows the real pin level
  localparam logic [1:0] SETTLE = 2'(SYNC_STAGES);

  logic cs_s, cs_rise, cs_fall;
  logic sclk_s, sclk_rise, sclk_fall;
  logic mosi_s, mosi_rise, mosi_fall;
  logic unused_edges;

  sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_cs (
    .clk_i(clk_in), .rst_ni(reset_n_in), .d_i(spi_cs_n_in),
    .q_o(cs_s), .rise_o(cs_rise), .fall_o(cs_fall));

  sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sclk (
    .clk_i(clk_in), .rst_ni(reset_n_in), .d_i(spi_sclk_in),
    .q_o(sclk_s), .rise_o(sclk_rise), .fall_o(sclk_fall));

  sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (
    .clk_i(clk_in), .rst_ni(reset_n_in), .d_i(spi_mosi_in),
    .q_o(mosi_s), .rise_o(mosi_rise), .fall_o(mosi_fall));

  assign unused_edges = ^{sclk_s, sclk_fall, mosi_rise, mosi_fall};

  state_e                 state_q, state_d;
  logic [3:0]             bit_cnt_q, bit_cnt_d;
  logic [7:0]             shreg_q, shreg_d;
  logic [7:0]             byte_q, byte_d;
  logic [WAVE_ADDR_W-1:0] addr_q, addr_d;
  logic                   stop_q, stop_d;
  logic [1:0]             settle_q, settle_d;
  logic                   en_q, en_d;
  logic [WAVE_ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [WAVE_DATA_W-1:0] wr_data_q, wr_data_d;
  logic                   done_q, done_d;
  logic                   err_q, err_d;
  logic                   busy_q, busy_d;
  logic [7:0]             shift_byte;

  assign shift_byte = {shreg_q[6:0], mosi_s};

  // State, datapath and registered outputs
  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      state_q   <= WAIT_IDLE;
      bit_cnt_q <= '0;
      shreg_q   <= '0;
      byte_q    <= '0;
      addr_q    <= '0;
      stop_q    <= 1'b0;
      settle_q  <= '0;
      en_q      <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shreg_q   <= shreg_d;
      byte_q    <= byte_d;
      addr_q    <= addr_d;
      stop_q    <= stop_d;
      settle_q  <= settle_d;
      en_q      <= en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      done_q    <= done_d;
      err_q     <= err_d;
      busy_q    <= busy_d;
    end
  end

  // Next-state and datapath updates; a cs_rise during a write pair is remembered in stop_q
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shreg_d   = shreg_q;
    byte_d    = byte_q;
    addr_d    = addr_q;
    stop_d    = stop_q;
    settle_d  = (settle_q == SETTLE) ? settle_q : settle_q + 2'd1;
    case (state_q)
      WAIT_IDLE: if (settle_q == SETTLE && cs_s) state_d = IDLE;
      IDLE: begin
        if (cs_fall) begin
          bit_cnt_d = '0;
          stop_d    = 1'b0;
          state_d   = CMD;
        end
      end
      CMD: begin
        if (cs_rise) begin
          state_d = IDLE;
        end else if (sclk_rise) begin
          shreg_d   = shift_byte;
          bit_cnt_d = bit_cnt_q + 4'd1;
          if (bit_cnt_q == 4'd7) begin
            bit_cnt_d = '0;
            if (shift_byte[7:5] == OPCODE) begin
              addr_d  = shift_byte[4:0];
              state_d = DATA;
            end else begin
              state_d = DISCARD;
            end
          end
        end
      end
      DATA: begin
        if (cs_rise || stop_q) begin
          stop_d  = 1'b0;
          state_d = IDLE;
        end else if (sclk_rise) begin
          shreg_d   = shift_byte;
          bit_cnt_d = bit_cnt_q + 4'd1;
          if (bit_cnt_q == 4'd7) begin
            byte_d  = shift_byte;
            state_d = WR_HI;
          end
        end
      end
      WR_HI: begin
        addr_d  = addr_q + 5'd1;
        if (cs_rise) stop_d = 1'b1;
        state_d = WR_LO;
      end
      WR_LO: begin
        addr_d    = addr_q + 5'd1;
        bit_cnt_d = '0;
        if (cs_rise) stop_d = 1'b1;
        state_d   = DATA;
      end
      DISCARD: if (cs_rise) state_d = IDLE;
      default: state_d = WAIT_IDLE;
    endcase
  end

  // Output decode: write strobes, frame/err pulses and busy, all registered next cycle
  always_comb begin
    en_d      = 1'b0;
    done_d    = 1'b0;
    err_d     = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    busy_d    = !(state_d inside {WAIT_IDLE, IDLE});
    case (state_q)
      CMD: begin
        if (!cs_rise && sclk_rise && bit_cnt_q == 4'd7 && shift_byte[7:5] != OPCODE)
          err_d = 1'b1;
      end
      DATA: if (cs_rise || stop_q) done_d = 1'b1;
      WR_HI: begin
        en_d      = 1'b1;
        wr_addr_d = addr_q;
        wr_data_d = byte_q[7:4];
      end
      WR_LO: begin
        en_d      = 1'b1;
        wr_addr_d = addr_q;
        wr_data_d = byte_q[3:0];
      end
      default: ;
    endcase
  end

  assign mem_write_addr_out = wr_addr_q;
  assign mem_write_data_out = wr_data_q;
  assign mem_write_en_out   = en_q;
  assign busy_out           = busy_q;
  assign frame_done_out     = done_q;
  assign cmd_err_out        = err_q;

endmodule

// File: tb/tb_wave_mem_loader.sv
// tb/tb_wave_mem_loader.sv - directed self-checking bench for wave_mem_loader
module tb_wave_mem_loader;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cs_n = 1'b0;
  logic       sclk = 1'b0;
  logic       mosi = 1'b0;
  logic [4:0] wr_addr;
  logic [3:0] wr_data;
  logic       wr_en;
  logic       busy;
  logic       done;
  logic       err;

  int pass_cnt = 0;
  int tot_cnt = 0;

  int       cyc = 0;
  int       done_cnt = 0;
  int       err_cnt = 0;
  int       busy_cnt = 0;
  int       wq_addr[$];
  int       wq_data[$];
  int       wq_cyc[$];

  wave_mem_loader dut (
    .clk_in(clk),
    .reset_n_in(rst_n),
    .spi_cs_n_in(cs_n),
    .spi_sclk_in(sclk),
    .spi_mosi_in(mosi),
    .mem_write_addr_out(wr_addr),
    .mem_write_data_out(wr_data),
    .mem_write_en_out(wr_en),
    .busy_out(busy),
    .frame_done_out(done),
    .cmd_err_out(err)
  );

  always #5 clk = ~clk;

  // Record every observable event away from the active edge
  always @(negedge clk) begin
    cyc = cyc + 1;
    if (wr_en) begin
      wq_addr.push_back(int'(wr_addr));
      wq_data.push_back(int'(wr_data));
      wq_cyc.push_back(cyc);
    end
    if (done) done_cnt = done_cnt + 1;
    if (err) err_cnt = err_cnt + 1;
    if (busy) busy_cnt = busy_cnt + 1;
  end

  task automatic spi_bit(input logic b);
    mosi = b;
    #40 sclk = 1'b1;
    #40 sclk = 1'b0;
  endtask

  task automatic spi_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) spi_bit(b[i]);
  endtask

  task automatic frame_start();
    cs_n = 1'b0;
    #40;
  endtask

  task automatic frame_end();
    #40 cs_n = 1'b1;
    repeat (20) @(posedge clk);
  endtask

  task automatic test_reset();
    int wb, db, bb;
    rst_n = 1'b0;
    cs_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    tot_cnt++;
    if ({wr_en, busy, done, err, wr_addr, wr_data} !== 13'd0)
      $display("FAIL reset_outputs got=%h want=0", {wr_en, busy, done, err, wr_addr, wr_data});
    else pass_cnt++;
    @(negedge clk) rst_n = 1'b1;
    repeat (10) @(posedge clk);
    wb = wq_addr.size(); db = done_cnt; bb = busy_cnt;
    spi_byte(8'hA0);
    spi_byte(8'h12);
    repeat (10) @(posedge clk);
    tot_cnt++;
    if (wq_addr.size() - wb !== 0) $display("FAIL held_cs_writes got=%0d want=0", wq_addr.size() - wb);
    else pass_cnt++;
    tot_cnt++;
    if (busy_cnt - bb !== 0) $display("FAIL held_cs_busy got=%0d want=0", busy_cnt - bb);
    else pass_cnt++;
    cs_n = 1'b1;
    repeat (10) @(posedge clk);
    wb = wq_addr.size(); db = done_cnt;
    frame_start();
    spi_byte(8'hA0);
    spi_byte(8'h12);
    frame_end();
    tot_cnt++;
    if (wq_addr.size() - wb !== 2) $display("FAIL reentry_count got=%0d want=2", wq_addr.size() - wb);
    else pass_cnt++;
    if (wq_addr.size() - wb == 2) begin
      tot_cnt++;
      if (wq_addr[wb] !== 0 || wq_data[wb] !== 1 || wq_addr[wb+1] !== 1 || wq_data[wb+1] !== 2)
        $display("FAIL reentry_writes got=(%0d,%0d)(%0d,%0d) want=(0,1)(1,2)",
                 wq_addr[wb], wq_data[wb], wq_addr[wb+1], wq_data[wb+1]);
      else pass_cnt++;
    end
    tot_cnt++;
    if (done_cnt - db !== 1) $display("FAIL reentry_done got=%0d want=1", done_cnt - db);
    else pass_cnt++;
  endtask

  task automatic test_full_frame();
    int wb, db;
    logic [7:0] b;
    wb = wq_addr.size(); db = done_cnt;
    frame_start();
    spi_byte(8'hA0);
    for (int k = 0; k < 16; k++) begin
      b = {4'((2 * k) & 15), 4'((2 * k + 1) & 15)};
      spi_byte(b);
    end
    frame_end();
    tot_cnt++;
    if (wq_addr.size() - wb !== 32) $display("FAIL full_count got=%0d want=32", wq_addr.size() - wb);
    else pass_cnt++;
    if (wq_addr.size() - wb == 32) begin
      for (int j = 0; j < 32; j++) begin
        tot_cnt++;
        if (wq_addr[wb+j] !== j || wq_data[wb+j] !== (j & 15))
          $display("FAIL full_write%0d got=(%0d,%0d) want=(%0d,%0d)", j,
                   wq_addr[wb+j], wq_data[wb+j], j, j & 15);
        else pass_cnt++;
      end
      for (int m = 0; m < 16; m++) begin
        tot_cnt++;
        if (wq_cyc[wb+2*m+1] - wq_cyc[wb+2*m] !== 1)
          $display("FAIL full_pair%0d gap got=%0d want=1", m, wq_cyc[wb+2*m+1] - wq_cyc[wb+2*m]);
        else pass_cnt++;
      end
    end
    tot_cnt++;
    if (done_cnt - db !== 1) $display("FAIL full_done got=%0d want=1", done_cnt - db);
    else pass_cnt++;
  endtask

  task automatic test_wrap();
    int wb;
    int ea[4] = '{30, 31, 0, 1};
    int ed[4] = '{5, 10, 12, 3};
    wb = wq_addr.size();
    frame_start();
    spi_byte(8'hBE);
    spi_byte(8'h5A);
    spi_byte(8'hC3);
    frame_end();
    tot_cnt++;
    if (wq_addr.size() - wb !== 4) $display("FAIL wrap_count got=%0d want=4", wq_addr.size() - wb);
    else pass_cnt++;
    if (wq_addr.size() - wb == 4) begin
      for (int j = 0; j < 4; j++) begin
        tot_cnt++;
        if (wq_addr[wb+j] !== ea[j] || wq_data[wb+j] !== ed[j])
          $display("FAIL wrap_write%0d got=(%0d,%0d) want=(%0d,%0d)", j,
                   wq_addr[wb+j], wq_data[wb+j], ea[j], ed[j]);
        else pass_cnt++;
      end
    end
  endtask

  task automatic test_cmd_err();
    int wb, db, eb;
    wb = wq_addr.size(); db = done_cnt; eb = err_cnt;
    frame_start();
    spi_byte(8'h7F);
    spi_byte(8'hFF);
    tot_cnt++;
    if (busy !== 1'b1) $display("FAIL err_busy_in_frame got=%b want=1", busy);
    else pass_cnt++;
    frame_end();
    tot_cnt++;
    if (err_cnt - eb !== 1) $display("FAIL err_pulses got=%0d want=1", err_cnt - eb);
    else pass_cnt++;
    tot_cnt++;
    if (wq_addr.size() - wb !== 0) $display("FAIL err_writes got=%0d want=0", wq_addr.size() - wb);
    else pass_cnt++;
    tot_cnt++;
    if (done_cnt - db !== 0) $display("FAIL err_done got=%0d want=0", done_cnt - db);
    else pass_cnt++;
    tot_cnt++;
    if (busy !== 1'b0) $display("FAIL err_busy_after got=%b want=0", busy);
    else pass_cnt++;
  endtask

  task automatic test_partial();
    int wb, db;
    wb = wq_addr.size(); db = done_cnt;
    frame_start();
    spi_byte(8'hA4);
    spi_byte(8'h90);
    spi_bit(1'b1);
    spi_bit(1'b0);
    spi_bit(1'b1);
    frame_end();
    tot_cnt++;
    if (wq_addr.size() - wb !== 2) $display("FAIL partial_count got=%0d want=2", wq_addr.size() - wb);
    else pass_cnt++;
    if (wq_addr.size() - wb == 2) begin
      tot_cnt++;
      if (wq_addr[wb] !== 4 || wq_data[wb] !== 9 || wq_addr[wb+1] !== 5 || wq_data[wb+1] !== 0)
        $display("FAIL partial_writes got=(%0d,%0d)(%0d,%0d) want=(4,9)(5,0)",
                 wq_addr[wb], wq_data[wb], wq_addr[wb+1], wq_data[wb+1]);
      else pass_cnt++;
    end
    tot_cnt++;
    if (done_cnt - db !== 1) $display("FAIL partial_done got=%0d want=1", done_cnt - db);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid_frame();
    int wb;
    frame_start();
    spi_byte(8'hA0);
    spi_byte(8'h11);
    spi_bit(1'b0);
    spi_bit(1'b1);
    spi_bit(1'b0);
    rst_n = 1'b0;
    #1;
    tot_cnt++;
    if ({wr_en, busy, done, err} !== 4'b0000)
      $display("FAIL midreset_outputs got=%b want=0000", {wr_en, busy, done, err});
    else pass_cnt++;
    wb = wq_addr.size();
    repeat (10) @(posedge clk);
    tot_cnt++;
    if (wq_addr.size() - wb !== 0) $display("FAIL midreset_writes got=%0d want=0", wq_addr.size() - wb);
    else pass_cnt++;
    cs_n = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    repeat (10) @(posedge clk);
    wb = wq_addr.size();
    frame_start();
    spi_byte(8'hA0);
    spi_byte(8'h77);
    frame_end();
    tot_cnt++;
    if (wq_addr.size() - wb !== 2) $display("FAIL after_reset_count got=%0d want=2", wq_addr.size() - wb);
    else pass_cnt++;
    if (wq_addr.size() - wb == 2) begin
      tot_cnt++;
      if (wq_addr[wb] !== 0 || wq_data[wb] !== 7 || wq_addr[wb+1] !== 1 || wq_data[wb+1] !== 7)
        $display("FAIL after_reset_writes got=(%0d,%0d)(%0d,%0d) want=(0,7)(1,7)",
                 wq_addr[wb], wq_data[wb], wq_addr[wb+1], wq_data[wb+1]);
      else pass_cnt++;
    end
  endtask

  initial begin
    test_reset();
    test_full_frame();
    test_wrap();
    test_cmd_err();
    test_partial();
    test_reset_mid_frame();
    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

endmodule
